// File: rtl/mult_div_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide sequencer.
// fsm_state mirrors the sequencer's internal state for observation.
interface mult_div_if #(
    parameter int DATA_WIDTH = 32
);
    // start is sampled only while busy is low; while busy is high, a HI/LO
    // instruction on start raises stall_req and must be held until it drops.
    logic                  start;
    logic [5:0]            function_code;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  busy;
    logic                  stall_req;
    logic                  done;
    logic                  div_by_zero;
    logic [1:0]            fsm_state;

    modport master (
        output start, function_code, operand_a, operand_b,
        input  hi, lo, busy, stall_req, done, div_by_zero, fsm_state
    );

    modport slave (
        input  start, function_code, operand_a, operand_b,
        output hi, lo, busy, stall_req, done, div_by_zero, fsm_state
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative shift-add multiplier / restoring divider with the HI/LO registers.
// One result bit per cycle, followed by a single sign-fixup cycle.
module mult_div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    mult_div_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [W-1:0]    p_hi;      // product high half, or partial remainder
    logic [W-1:0]    p_lo;      // multiplier shifting out, or quotient shifting in
    logic [W-1:0]    m_reg;     // multiplicand, or divisor
    logic            negate;
    logic            rem_neg;
    logic            div_op;
    logic            dz;
    logic [W-1:0]    hi_reg;
    logic [W-1:0]    lo_reg;
    logic            done_reg;
    logic            dz_reg;

    logic [5:0]      funct;
    logic            is_muldiv, is_div, is_signed, is_mthi, is_mtlo, hilo_code;
    logic            sign_a, sign_b;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_shift;
    logic [W+1:0]    div_diff;
    logic [2*W-1:0]  product, product_fix;

    assign funct     = bus.function_code;
    assign is_muldiv = (funct[5:2] == 4'b0110);
    assign is_div    = is_muldiv & funct[1];
    assign is_signed = ~funct[0];
    assign is_mthi   = (funct == 6'b010001);
    assign is_mtlo   = (funct == 6'b010011);
    assign hilo_code = (funct[5:4] == 2'b01) & ~funct[2];

    // Magnitudes: the most negative value maps onto itself, which reads correctly as unsigned.
    assign sign_a = bus.operand_a[W-1];
    assign sign_b = bus.operand_b[W-1];
    assign abs_a  = (is_signed && sign_a) ? -bus.operand_a : bus.operand_a;
    assign abs_b  = (is_signed && sign_b) ? -bus.operand_b : bus.operand_b;

    assign mul_sum     = {1'b0, p_hi} + {1'b0, (p_lo[0] ? m_reg : {W{1'b0}})};
    assign rem_shift   = {p_hi, p_lo[W-1]};
    assign div_diff    = {1'b0, rem_shift} - {2'b00, m_reg};
    assign product     = {p_hi, p_lo};
    assign product_fix = negate ? -product : product;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            m_reg    <= '0;
            negate   <= 1'b0;
            rem_neg  <= 1'b0;
            div_op   <= 1'b0;
            dz       <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && is_muldiv) begin
                        counter <= '0;
                        p_hi    <= '0;
                        if (is_div && bus.operand_b == '0) begin
                            // Quotient all-ones, remainder = dividend, via the normal fixup path.
                            p_hi    <= bus.operand_a;
                            p_lo    <= '1;
                            negate  <= 1'b0;
                            rem_neg <= 1'b0;
                            div_op  <= 1'b1;
                            dz      <= 1'b1;
                            state   <= FIX;
                        end else if (is_div) begin
                            m_reg   <= abs_b;
                            p_lo    <= abs_a;
                            negate  <= is_signed & (sign_a ^ sign_b);
                            rem_neg <= is_signed & sign_a;
                            div_op  <= 1'b1;
                            dz      <= 1'b0;
                            state   <= DIV;
                        end else begin
                            m_reg   <= abs_a;
                            p_lo    <= abs_b;
                            negate  <= is_signed & (sign_a ^ sign_b);
                            rem_neg <= 1'b0;
                            div_op  <= 1'b0;
                            dz      <= 1'b0;
                            state   <= MUL;
                        end
                    end else if (bus.start && is_mthi) begin
                        hi_reg <= bus.operand_a;
                    end else if (bus.start && is_mtlo) begin
                        lo_reg <= bus.operand_a;
                    end
                end
                MUL: begin
                    p_hi    <= mul_sum[W:1];
                    p_lo    <= {mul_sum[0], p_lo[W-1:1]};
                    counter <= counter + 1'b1;
                    if (counter == CW'(W - 1)) state <= FIX;
                end
                DIV: begin
                    // Remainder stays below the divisor, so a passing trial fits in W bits.
                    p_hi    <= div_diff[W+1] ? rem_shift[W-1:0] : div_diff[W-1:0];
                    p_lo    <= {p_lo[W-2:0], ~div_diff[W+1]};
                    counter <= counter + 1'b1;
                    if (counter == CW'(W - 1)) state <= FIX;
                end
                FIX: begin
                    if (div_op) begin
                        lo_reg <= negate  ? -p_lo : p_lo;
                        hi_reg <= rem_neg ? -p_hi : p_hi;
                    end else begin
                        {hi_reg, lo_reg} <= product_fix;
                    end
                    done_reg <= 1'b1;
                    dz_reg   <= dz;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;
    assign bus.busy        = (state != IDLE);
    assign bus.stall_req   = bus.start & bus.busy & hilo_code;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dz_reg;
    assign bus.fsm_state   = state;
endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

- Iterative multiply/divide unit with its sequencer and the architectural HI/LO registers, placed in the EX stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO by R-type function code.
- Runs a 32-step shift-add multiply or restoring divide and writes HI/LO.
- Raises a stall request to the hazard logic while any HI/LO instruction cannot yet be serviced.

## Interface

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  EX holds a valid R-type instruction this cycle.
- function_code  in  6  R-type funct field.
- operand_a  in  DATA_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- operand_b  in  DATA_WIDTH  rt value (multiplier / divisor).
- hi  out  DATA_WIDTH  HI register, read by MFHI.
- lo  out  DATA_WIDTH  LO register, read by MFLO.
- busy  out  1  state != IDLE (registered).
- stall_req  out  1  combinational: start & busy & funct is any of the 8 HI/LO codes.
- done  out  1  one-cycle pulse, the cycle after HI/LO are written.
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with operand_b == 0.

## Operation

- Function codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Other codes are ignored.
- **Reset:** state IDLE; hi, lo, done, div_by_zero, counter and all internal datapath registers 0.
- **Accepting a start:** a start is accepted only in IDLE. With busy high, start is ignored and stall_req asserts; the pipeline re-presents the instruction.

States:
- **IDLE**
  - MULT/MULTU: latch |a| and |b| (signed ops, two's-complement magnitude as unsigned; 0x80000000 stays 0x80000000) or raw operands (unsigned ops). Latch negate flag = sign_a ^ sign_b (signed only), counter = 0, go MUL.
  - DIV/DIVU, operand_b != 0: same magnitude latching. Also latch rem_neg = sign_a (signed only). Remainder register = 0, go DIV.
  - DIV/DIVU, operand_b == 0: go FIX with result forced to HI = operand_a, LO = 0xFFFFFFFF; set dz flag.
  - MTHI / MTLO: hi / lo <= operand_a at this edge; stay IDLE; no done.
  - MFHI / MFLO: no state change.
- **MUL:** 64-bit product {P_hi, P_lo}, P_lo initialized to the multiplier.
  - Each edge: if P_lo[0], P_hi + multiplicand with a 33-bit sum.
  - Then shift the whole {carry, P_hi, P_lo} right by 1.
  - counter++; at counter == 31 go FIX.
- **DIV:** restoring divide.
  - Each edge: shift {R, Q} left by 1, where Q is initialized to the dividend.
  - Trial subtract R − divisor in 33 bits. If non-negative, R = difference and Q[0] = 1; else keep R and Q[0] = 0.
  - counter++; at counter == 31 go FIX.
- **FIX** (1 cycle):
  - Multiply: {hi, lo} = negate ? −product : product (64-bit two's complement).
  - Divide: lo = negate ? −Q : Q; hi = rem_neg ? −R : R.
  - Division overflow 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0 (wrap, no trap).
  - done <= 1; div_by_zero <= dz; go IDLE.
- done and div_by_zero are 0 in every cycle other than the one following FIX.

## Timing

- Accepting edge T (IDLE, start, mult/div code, no divide-by-zero):
  - MUL/DIV occupy edges T+1..T+32.
  - FIX writes hi/lo at edge T+33.
  - busy is high in cycles T+1..T+33.
  - done is high in cycle T+34 (first cycle after T+33).
- Divide-by-zero: FIX at edge T+1, busy high one cycle, done in the cycle after T+1.
- MTHI/MTLO: hi/lo visible the cycle after edge T; zero stall.
- MFHI/MFLO reads hi/lo combinationally. Issued while busy (including the FIX cycle), it stalls until busy drops, then reads the new value. No bypass of in-flight results.
- Back-to-back: a new MULT/DIV may be accepted in the first cycle busy is low (same cycle as done).
- reset asserted in any state overrides everything at the next edge. The operation in flight is abandoned; hi/lo are cleared to 0.

## Test plan

- MULT a=0xFFFFFFFD (−3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles, done on cycle 34.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT of the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, done and div_by_zero high together in cycle 2 after accept, busy high one cycle.
- MULT accepted, then MFHI held on start from cycle 2 -> stall_req high through cycle 33, low in cycle 34 with hi showing the new product. A second MULT presented during busy is not accepted.
- MTLO 0xCAFE, then reset pulsed at cycle 10 of a subsequent DIV -> next cycle busy=0, hi=lo=0, done never pulses. A following MTHI 5 gives hi=5 one cycle later.
